// File: rtl/hazard_if.sv
// Bundle of stall requests, branch resolution and sequencer outputs shared
// between the pipeline (master) and hazard_ctrl (slave).
interface hazard_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        ex_branch_flag;
  logic [31:0] ex_branch_addr;
  logic [4:0]  stalled;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           ex_branch_flag, ex_branch_addr,
    input  stalled, flush_if_id, flush_id_ex, redirect, redirect_addr,
           stall_timeout, perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           ex_branch_flag, ex_branch_addr,
    output stalled, flush_if_id, flush_id_ex, redirect, redirect_addr,
           stall_timeout, perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: stall merge, flush/redirect with pending branch,
// stall watchdog. Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl #(
  parameter int TO_W          = 10,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);

  localparam logic [0:0]      RUN       = 1'b0;
  localparam logic [0:0]      PEND      = 1'b1;
  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(STALL_TIMEOUT);

  logic [0:0]      state, state_nxt;
  logic [31:0]     pend_addr, pend_addr_nxt;
  logic [TO_W-1:0] wd_cnt;
  logic [4:0]      stall_raw;
  logic            branch_take;
  logic            flush;

  // A branch only resolves when EX and MEM are both advancing.
  assign branch_take = bus.ex_branch_flag & ~bus.stallreq_mem & ~bus.stallreq_ex;

  // NOTE: every signal written here gets a default first, so no latch can form.
  always_comb begin
    state_nxt         = state;
    pend_addr_nxt     = pend_addr;
    flush             = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    case (state)
      RUN: begin
        if (branch_take) begin
          flush = 1'b1;
          if (!bus.stallreq_if) begin
            bus.redirect      = 1'b1;
            bus.redirect_addr = bus.ex_branch_addr;
          end else begin
            pend_addr_nxt = bus.ex_branch_addr;
            state_nxt     = PEND;
          end
        end
      end
      default: begin
        // EX holds a bubble while pending, so a new branch flag is ignored.
        flush = 1'b1;
        if (!bus.stallreq_if) begin
          bus.redirect      = 1'b1;
          bus.redirect_addr = pend_addr;
          state_nxt         = RUN;
        end
      end
    endcase
  end

  always_comb begin
    if (bus.stallreq_mem)     stall_raw = 5'b11111;
    else if (bus.stallreq_ex) stall_raw = 5'b01111;
    else if (bus.stallreq_id) stall_raw = 5'b00111;
    else if (bus.stallreq_if) stall_raw = 5'b00011;
    else                      stall_raw = 5'b00000;
  end

  // Flush wins over stall on IF/ID and ID/EX so the bubble actually enters.
  assign bus.stalled     = flush ? (stall_raw & 5'b11001) : stall_raw;
  assign bus.flush_if_id = flush;
  assign bus.flush_id_ex = flush;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wd_cnt <= '0;
    else if (~|bus.stalled)      wd_cnt <= '0;
    else if (wd_cnt < TIMEOUT_V) wd_cnt <= wd_cnt + 1'b1;
  end

  // Flag drops on the first unstalled cycle, before the counter clears.
  assign bus.stall_timeout = (wd_cnt == TIMEOUT_V) && (|bus.stalled);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (bus.stalled[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)          perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushes      = perf_flush_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flushes      = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Merges per-stage stall requests into the `stalled[4:0]` vector consumed by all pipeline registers.
- Generates flush strobes and the PC redirect. Holds a taken branch pending while fetch is stalled.
- Watches for stalls that last too long.

Parameters:
- TO_W, 10, width of the consecutive-stall watchdog counter.
- STALL_TIMEOUT, 1023, number of consecutive stalled cycles that raises the timeout flag; must be ≤ 2^TO_W−1.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- stallreq_if_i  in  1  instruction bus not ready
- stallreq_id_i  in  1  load-use hazard in decode
- stallreq_ex_i  in  1  multi-cycle EX op (div) busy
- stallreq_mem_i  in  1  data bus not ready
- ex_branch_flag_i  in  1  EX resolved a taken branch/jump
- ex_branch_addr_i  in  32  branch target
- stalled_o  out  5  bit k = 1 stops stage-k register (bit0 PC … bit4 MEM/WB)
- flush_if_id_o  out  1  bubble IF/ID
- flush_id_ex_o  out  1  bubble ID/EX
- redirect_o  out  1  load PC from redirect_addr_o this cycle
- redirect_addr_o  out  32  PC target
- stall_timeout_o  out  1  watchdog expired (sticky while stall persists)
- perf_stall_cycles_o  out  32  see Optional Feature
- perf_flushes_o  out  32  see Optional Feature

Behaviour:
- Reset (async, rst=1): FSM=RUN, pending addr=0, watchdog count=0, all outputs 0.
- stalled_o is combinational, 0-latency. The highest requesting stage wins:
  - mem → 11111
  - ex → 01111
  - id → 00111
  - if → 00011
  - none → 00000
- Pipeline registers insert a bubble where stalled[k]=1 and stalled[k+1]=0. This block does not drive that bubble.
- FSM states:
  - RUN:
    - ex_branch_flag_i=1 and stallreq_mem_i=0 and stallreq_ex_i=0:
      - stallreq_if_i=0: same cycle redirect_o=1, redirect_addr_o=ex_branch_addr_i, flush_if_id_o=1, flush_id_ex_o=1; stay RUN.
      - stallreq_if_i=1: latch ex_branch_addr_i; flush_if_id_o=flush_id_ex_o=1 this cycle; go PEND.
    - Branch with mem/ex stall: ignored. EX holds and re-presents the branch later.
  - PEND:
    - Every cycle: flush_if_id_o=flush_id_ex_o=1; new ex_branch_flag_i ignored, since EX holds a bubble.
    - When stallreq_if_i=0: redirect_o=1 with the latched address, then go RUN.
- redirect_o is 1 for exactly one cycle per taken branch.
- Flush overrides stall for IF/ID and ID/EX: while a flush is asserted, stalled_o bits 1–2 are forced 0 so the bubble enters.
- Watchdog:
  - Count increments each cycle stalled_o≠0 and clears on any cycle stalled_o=0.
  - Count saturates at STALL_TIMEOUT.
  - stall_timeout_o=1 while count==STALL_TIMEOUT.
- Reset mid-PEND: the pending redirect is discarded and the FSM returns to RUN.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cycles_o increments each cycle stalled_o[0]=1.
  - perf_flushes_o increments on each cycle flush_if_id_o=1.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesized.

Test Plan:
1. Requests if=1 and mem=1 in the same cycle → stalled_o=11111. Then mem=0, ex=1 → 01111. Then id only → 00111. Then all 0 → 00000.
2. Branch, no stalls: ex_branch_flag_i=1, addr=0x0000_0100 → same cycle redirect_o=1, redirect_addr_o=0x100, both flushes 1, stalled_o[2:1]=00. Next cycle redirect_o=0.
3. Branch with fetch stall: stallreq_if_i=1 for 3 cycles, branch pulse addr=0x0000_2000 in cycle 0 → flushes high cycles 0–3, redirect_o=0 cycles 0–2, redirect_o=1 with 0x2000 in cycle 3 (if drops), back to RUN.
4. Branch during mem stall → no redirect, no flush. Branch re-held until mem=0 → redirect in the first cycle mem=0.
5. Watchdog with STALL_TIMEOUT=4: stallreq_ex_i high for 6 cycles → stall_timeout_o=1 from cycle 4 through 5, 0 the cycle after the stall clears.
6. rst pulsed during PEND → redirect_o never asserts, all outputs 0. With HAZARD_PERF_EN, after scenario 3 perf_flushes_o=4 (counters reset to 0 by the rst pulse).
